// File: rtl/pipe_reg_layer.sv
// pipe_reg_layer: DEPTH-stage elastic valid/ready pipeline register
// with per-stage bubble collapsing, synchronous flush and occupancy count.
module pipe_reg_layer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] v_q, v_d, mv;
    logic [CW-1:0]    count_q, count_d;
    logic             ld0, in_x, out_x;

    // A stage advances when the next one is empty or itself moving.
    always_comb begin
        mv = '0;
        mv[DEPTH-1] = v_q[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--)
            mv[i] = v_q[i] & (~v_q[i+1] | mv[i+1]);
    end

    assign ld0       = ~v_q[0] | mv[0];
    assign in_ready  = ld0 & ~flush;
    assign in_x      = in_valid & in_ready;
    assign out_x     = mv[DEPTH-1];
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign count     = count_q;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        v_d[0] = ld0 ? in_valid : v_q[0];
        d_d[0] = ld0 ? in_data : d_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            v_d[i] = mv[i-1] | (~mv[i] & v_q[i]);
            d_d[i] = mv[i-1] ? d_q[i-1] : d_q[i];
        end
        count_d = count_q + CW'(in_x) - CW'(out_x);
        if (flush) begin
            v_d = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) d_d[i] = RESET_VAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= RESET_VAL;
        end else begin
            v_q <= v_d;
            count_q <= count_d;
            d_q <= d_d;
        end
    end
endmodule
